bp_me_wormhole_tx_mem_cmd: RTL and testbench
============================================

# bp_me_wormhole_tx_mem_cmd

Sequential wormhole transmitter for memory commands. Accepts one memory command (message header, payload, routing coordinates) per handshake, builds the wormhole header with a `len` field computed from the payload size and data-presence, then serialises header and payload into `flit_width_p`-bit flits on a ready/valid link. Sits between the CCE/IO memory-command source and the mem NoC router port. It replaces purely combinational header encoding plus external serialisation.

## Interface
Parameters:
- flit_width_p, 64, link flit width in bits
- cord_width_p, 7, coordinate width
- cid_width_p, 2, concentrator id width
- len_width_p, 5, wormhole len field width
- msg_hdr_width_p, 60, memory message header width
- data_width_p, 512, maximum payload width in bits; must be a multiple of 8

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-high reset
- msg_hdr_i  in  msg_hdr_width_p  memory command header, transmitted verbatim
- size_i  in  3  payload size as log2(bytes): 0=1B … 7=128B
- has_data_i  in  1  1 = command carries payload (writes, SC, AMOs); 0 = header only (reads, LR, prefetch)
- data_i  in  data_width_p  payload, LSB-aligned
- src_cord_i / dst_cord_i  in  cord_width_p  source / destination coordinate
- src_cid_i / dst_cid_i  in  cid_width_p  source / destination cid
- v_i  in  1  command valid
- ready_and_o  out  1  command accept
- flit_o  out  flit_width_p  outgoing flit
- v_o  out  1  flit valid
- ready_and_i  in  1  downstream accept

## Operation
- Wormhole header H, LSB first: dst_cord, len, dst_cid, src_cord, src_cid, msg_hdr. Width HW = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_hdr_width_p.
- Payload bytes B = min(2^size_i, data_width_p/8). Payload bits P = has_data_i ? 8*B : 0. Bits of data_i above 8*B are zeroed before transmission.
- Flits N = ceil((HW+P)/flit_width_p); len = N-1, truncated to len_width_p.
- Elaboration-time assertion: ceil((HW+data_width_p)/flit_width_p)-1 < 2^len_width_p. Also asserted: flit_width_p >= 2*cord_width_p + len_width_p + 2*cid_width_p.
- Packet register, width HW+data_width_p, loaded with {masked payload, H}. flit_o is always its low flit_width_p bits. Each flit handshake shifts it right by flit_width_p, zero-filled.
- Down-counter cnt, width len_width_p, loaded with len on accept.
- State machine:
  - IDLE: ready_and_o=1, v_o=0. On v_i&ready_and_o, load the register and cnt, then go to SEND.
  - SEND: v_o=1, ready_and_o=0. On v_o&ready_and_i with cnt≠0, shift and decrement cnt. With cnt=0, this is the last flit; go to IDLE.
- The state machine never drops or duplicates a flit. Input fields are sampled only on the accept cycle; later changes are ignored.

## Timing
- Reset (asynchronous assert): state=IDLE, v_o=0, packet register=0, cnt=0. ready_and_o=0 while reset_i is high and 1 in the first cycle after release.
- Latency: command accepted in cycle t gives first flit valid in cycle t+1, driven from registers with no combinational path from inputs.
- With downstream always ready, a packet of N flits occupies cycles t+1..t+N, and ready_and_o rises at t+N+1. Throughput is one packet per N+1 cycles.
- ready_and_o and v_o are purely state-decoded, with no combinational dependence on v_i or ready_and_i.
- Backpressure: while v_o=1 and ready_and_i=0, flit_o, v_o and cnt hold.
- Reset mid-packet aborts the packet immediately. No partial flits follow; the state returns to IDLE.
- Back-to-back commands: v_i held high in SEND is not accepted until IDLE.

## Test plan
All cases use default parameters, so HW=83.
- Read, has_data_i=0, size_i=6, downstream always ready -> N=2, len=1. Flit0[6:0]=dst_cord, flit0[11:7]=1. Two consecutive v_o cycles, then ready_and_o=1.
- Write, size_i=6 (64B), data_i=incrementing bytes -> len=9, 10 flits. The reassembled 595 bits equal {data, H}. Flit9 upper bits are 0.
- Write, size_i=3 (8B), data_i=all ones -> len=2, 3 flits. Bits 147+ of the reassembled packet are 0, confirming payload masking.
- Size clamp: size_i=7, has_data_i=1 -> B=64, len=9, same flit count as the 64B case.
- Random ready_and_i (50%) over 200 mixed commands -> flit order, content and count match a reference model, and held flits stay stable during stalls.
- Assert reset_i during flit 4 of a 10-flit write -> v_o falls asynchronously. After release, IDLE with ready_and_o=1, and the next read emits exactly 2 correct flits.

Source files
------------

// File: rtl/bp_me_wormhole_tx_mem_cmd.sv
// ---------------------------------------------------------------------------
// bp_me_wormhole_tx_mem_cmd
//
// Sequential wormhole transmitter for memory commands. One command (header,
// payload, routing coordinates) is captured per handshake. The wormhole
// header carries a len field derived from the payload size and data presence.
// Header and payload are then shifted out as flit_width_p-bit flits.
//
// Wormhole header, LSB first:
//   dst_cord | len | dst_cid | src_cord | src_cid | msg_hdr
//
// Ports
//   clk_i        clock
//   reset_i      asynchronous active-high reset
//   msg_hdr_i    memory command header, sent verbatim
//   size_i       payload size as log2(bytes), clamped to data_width_p/8
//   has_data_i   1 = command carries a payload
//   data_i       payload, LSB-aligned; bytes beyond the size are zeroed
//   src_cord_i   source coordinate
//   dst_cord_i   destination coordinate
//   src_cid_i    source concentrator id
//   dst_cid_i    destination concentrator id
//   v_i          command valid
//   ready_and_o  command accept; high only in IDLE and out of reset
//   flit_o       outgoing flit (low bits of the packet register)
//   v_o          flit valid; high only in SEND
//   ready_and_i  downstream accept
// ---------------------------------------------------------------------------
module bp_me_wormhole_tx_mem_cmd #(
    parameter int flit_width_p    = 64,
    parameter int cord_width_p    = 7,
    parameter int cid_width_p     = 2,
    parameter int len_width_p     = 5,
    parameter int msg_hdr_width_p = 60,
    parameter int data_width_p    = 512
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [msg_hdr_width_p-1:0] msg_hdr_i,
    input  logic [2:0]                 size_i,
    input  logic                       has_data_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic [cord_width_p-1:0]    src_cord_i,
    input  logic [cord_width_p-1:0]    dst_cord_i,
    input  logic [cid_width_p-1:0]     src_cid_i,
    input  logic [cid_width_p-1:0]     dst_cid_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    output logic [flit_width_p-1:0]    flit_o,
    output logic                       v_o,
    input  logic                       ready_and_i
);

    localparam int hdr_width_lp  = 2*cord_width_p + 2*cid_width_p + len_width_p + msg_hdr_width_p;
    localparam int pkt_width_lp  = hdr_width_lp + data_width_p;
    localparam int data_bytes_lp = data_width_p / 8;
    localparam int max_len_lp    = (pkt_width_lp + flit_width_p - 1) / flit_width_p - 1;

    // Parameter sanity: the longest packet must fit the len field, and the
    // routing fields must all land in the first flit.
    if (max_len_lp >= (1 << len_width_p)) begin : g_len_too_narrow
        $error("len_width_p too small for the largest packet");
    end
    if (flit_width_p < 2*cord_width_p + len_width_p + 2*cid_width_p) begin : g_flit_too_narrow
        $error("flit_width_p cannot hold the routing fields");
    end
    if ((data_width_p % 8) != 0) begin : g_data_not_bytes
        $error("data_width_p must be a multiple of 8");
    end

    typedef enum logic {
        e_idle,
        e_send
    } state_e;

    state_e                    state;
    logic [pkt_width_lp-1:0]   pkt;
    logic [len_width_p-1:0]    cnt;

    logic [31:0]               pay_bytes;
    logic [31:0]               pay_bits;
    logic [31:0]               num_flits;
    logic [len_width_p-1:0]    len;
    logic [data_width_p-1:0]   data_masked;
    logic [hdr_width_lp-1:0]   hdr;

    // Length and payload masking from the incoming command fields.
    always_comb begin
        // NOTE: every signal gets a default before any conditional update so
        // no path leaves it unassigned and no latch is inferred.
        pay_bytes   = 32'd1 << size_i;
        pay_bits    = '0;
        num_flits   = '0;
        data_masked = '0;

        if (pay_bytes > 32'(data_bytes_lp)) begin
            pay_bytes = 32'(data_bytes_lp);
        end
        if (has_data_i) begin
            pay_bits = pay_bytes << 3;
        end
        num_flits = (32'(hdr_width_lp) + pay_bits + 32'(flit_width_p) - 32'd1)
                    / 32'(flit_width_p);

        // Keep only the bytes that belong to the payload; a header-only
        // command sends no data bits at all.
        for (int i = 0; i < data_bytes_lp; i++) begin
            if (has_data_i && (32'(i) < pay_bytes)) begin
                data_masked[i*8 +: 8] = data_i[i*8 +: 8];
            end
        end
    end

    assign len = len_width_p'(num_flits - 32'd1);
    assign hdr = {msg_hdr_i, src_cid_i, src_cord_i, dst_cid_i, len, dst_cord_i};

    // Outputs come straight from state and the packet register, so there is
    // no combinational path from v_i or ready_and_i to the link side.
    assign v_o         = (state == e_send);
    assign ready_and_o = (state == e_idle) && !reset_i;
    assign flit_o      = pkt[flit_width_p-1:0];

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: the packet register is reset too, so flit_o is a known zero
        // after reset rather than stale data from an aborted packet.
        if (reset_i) begin
            state <= e_idle;
            pkt   <= '0;
            cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from
            // the pre-edge values, independent of statement order.
            case (state)
                e_idle: begin
                    if (v_i && ready_and_o) begin
                        pkt   <= {data_masked, hdr};
                        cnt   <= len;
                        state <= e_send;
                    end
                end
                e_send: begin
                    if (ready_and_i) begin
                        if (cnt != '0) begin
                            pkt <= pkt >> flit_width_p;
                            cnt <= cnt - len_width_p'(1);
                        end else begin
                            state <= e_idle;
                        end
                    end
                end
                default: state <= e_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_me_wormhole_tx_mem_cmd.sv
// ---------------------------------------------------------------------------
// Testbench for bp_me_wormhole_tx_mem_cmd (default parameters, HW = 83).
// Directed table vectors, a back-to-back sequence, a mid-packet reset and a
// randomized run with 50% downstream backpressure, all compared against a
// packet model built from the field layout and length rules.
// ---------------------------------------------------------------------------
module tb_bp_me_wormhole_tx_mem_cmd;

    localparam int FW  = 64;
    localparam int HW  = 83;
    localparam int PW  = HW + 512;
    localparam int GW  = 640;   // ten flits of capture space

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [59:0]   msg_hdr_i;
    logic [2:0]    size_i;
    logic          has_data_i;
    logic [511:0]  data_i;
    logic [6:0]    src_cord_i, dst_cord_i;
    logic [1:0]    src_cid_i, dst_cid_i;
    logic          v_i;
    logic          ready_and_o;
    logic [63:0]   flit_o;
    logic          v_o;
    logic          ready_and_i;

    int checks = 0;
    int errors = 0;

    bp_me_wormhole_tx_mem_cmd dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .msg_hdr_i   (msg_hdr_i),
        .size_i      (size_i),
        .has_data_i  (has_data_i),
        .data_i      (data_i),
        .src_cord_i  (src_cord_i),
        .dst_cord_i  (dst_cord_i),
        .src_cid_i   (src_cid_i),
        .dst_cid_i   (dst_cid_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .flit_o      (flit_o),
        .v_o         (v_o),
        .ready_and_i (ready_and_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [59:0]  hdr;
        logic [2:0]   size;
        logic         hd;
        logic [511:0] data;
        logic [6:0]   sc;
        logic [6:0]   dc;
        logic [1:0]   sci;
        logic [1:0]   dci;
    } cmd_t;

    typedef struct {
        logic [2:0] size;
        logic       hd;
        int         dkind;    // 0 incrementing bytes, 1 all ones, 2 random
        int         exp_len;
    } vec_t;

    task automatic check(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.hdr  = {$urandom, $urandom};
        c.size = 3'($urandom_range(7, 0));
        c.hd   = 1'($urandom_range(1, 0));
        c.data = rand_data();
        c.sc   = 7'($urandom);
        c.dc   = 7'($urandom);
        c.sci  = 2'($urandom);
        c.dci  = 2'($urandom);
        return c;
    endfunction

    // Reference: payload byte count clamps at 64, flit count is found by
    // peeling 64-bit chunks off the total bit count.
    task automatic model_pkt(input cmd_t c, output logic [PW-1:0] p, output int n);
        int bytes, pbits;
        logic [4:0] len;
        bytes = 1 << c.size;
        if (bytes > 64) bytes = 64;
        pbits = c.hd ? bytes * 8 : 0;
        n = 0;
        for (int r = HW + pbits; r > 0; r -= FW) n++;
        len = 5'(n - 1);
        p = '0;
        p[6:0]   = c.dc;
        p[11:7]  = len;
        p[13:12] = c.dci;
        p[20:14] = c.sc;
        p[22:21] = c.sci;
        p[82:23] = c.hdr;
        for (int b = 0; b < pbits; b++) p[HW + b] = c.data[b];
    endtask

    task automatic drive_cmd(input cmd_t c);
        msg_hdr_i  = c.hdr;
        size_i     = c.size;
        has_data_i = c.hd;
        data_i     = c.data;
        src_cord_i = c.sc;
        dst_cord_i = c.dc;
        src_cid_i  = c.sci;
        dst_cid_i  = c.dci;
    endtask

    // Issue one command, collect its flits with rdy_pct% downstream ready,
    // and compare everything against the model.
    task automatic transact(input cmd_t c, input int rdy_pct, input string tag,
                            output logic [GW-1:0] got, output int nf);
        logic [PW-1:0] exp_pkt;
        logic [63:0]   held;
        int            n, cyc, hold_err, rdy_err;
        bit            stalled;
        model_pkt(c, exp_pkt, n);

        @(negedge clk_i);
        drive_cmd(c);
        v_i = 1'b1;
        ready_and_i = 1'b0;
        cyc = 0;
        while (!ready_and_o && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
        end
        check({tag, "_accept_timeout"}, GW'(cyc >= 100), GW'(0));
        @(negedge clk_i);
        v_i = 1'b0;
        drive_cmd(rand_cmd());   // later input changes must be ignored
        check({tag, "_latency_v"}, GW'(v_o), GW'(1));

        got = '0; nf = 0; cyc = 0; stalled = 0; hold_err = 0; rdy_err = 0; held = '0;
        while (nf < n && cyc < 2000) begin
            if (stalled && (!v_o || flit_o !== held)) hold_err++;
            if (v_o && ready_and_o) rdy_err++;
            ready_and_i = ($urandom_range(99, 0) < rdy_pct);
            if (v_o && ready_and_i) begin
                if (nf < 10) got[nf*64 +: 64] = flit_o;
                nf++;
                stalled = 0;
            end else if (v_o) begin
                stalled = 1;
                held = flit_o;
            end
            @(negedge clk_i);
            cyc++;
        end
        ready_and_i = 1'b0;
        check({tag, "_flit_count"}, GW'(nf), GW'(n));
        check({tag, "_packet"}, got, GW'(exp_pkt));
        check({tag, "_hold"}, GW'(hold_err), GW'(0));
        check({tag, "_busy_ready"}, GW'(rdy_err), GW'(0));
        check({tag, "_no_extra_flit"}, GW'(v_o), GW'(0));
        check({tag, "_ready_back"}, GW'(ready_and_o), GW'(1));
    endtask

    vec_t           vecs[8];
    cmd_t           c;
    logic [GW-1:0]  got;
    int             nf;
    logic [5:0]     vpat, rpat;

    initial begin
        vecs[0] = '{size: 3'd6, hd: 1'b0, dkind: 2, exp_len: 1};  // read
        vecs[1] = '{size: 3'd6, hd: 1'b1, dkind: 0, exp_len: 9};  // 64B write
        vecs[2] = '{size: 3'd3, hd: 1'b1, dkind: 1, exp_len: 2};  // 8B write
        vecs[3] = '{size: 3'd7, hd: 1'b1, dkind: 1, exp_len: 9};  // clamp
        vecs[4] = '{size: 3'd0, hd: 1'b1, dkind: 1, exp_len: 1};  // 1B
        vecs[5] = '{size: 3'd5, hd: 1'b1, dkind: 2, exp_len: 5};  // 32B
        vecs[6] = '{size: 3'd4, hd: 1'b1, dkind: 2, exp_len: 3};  // 16B
        vecs[7] = '{size: 3'd2, hd: 1'b0, dkind: 1, exp_len: 1};  // no data

        reset_i = 1'b1;
        v_i = 1'b0;
        ready_and_i = 1'b0;
        drive_cmd(rand_cmd());
        #3;
        check("reset_v_o", GW'(v_o), GW'(0));
        check("reset_ready", GW'(ready_and_o), GW'(0));
        check("reset_flit", GW'(flit_o), GW'(0));
        #20;
        reset_i = 1'b0;
        #1;
        check("release_ready", GW'(ready_and_o), GW'(1));
        check("release_v_o", GW'(v_o), GW'(0));

        // Directed vectors, downstream always ready.
        for (int i = 0; i < 8; i++) begin
            c = rand_cmd();
            c.size = vecs[i].size;
            c.hd   = vecs[i].hd;
            for (int b = 0; b < 64; b++) begin
                case (vecs[i].dkind)
                    0:       c.data[b*8 +: 8] = 8'(b);
                    1:       c.data[b*8 +: 8] = 8'hff;
                    default: ;
                endcase
            end
            transact(c, 100, $sformatf("vec%0d", i), got, nf);
            check($sformatf("vec%0d_len_field", i), GW'(got[11:7]), GW'(vecs[i].exp_len));
            check($sformatf("vec%0d_dst_cord", i), GW'(got[6:0]), GW'(c.dc));
            if (vecs[i].dkind == 1 && vecs[i].size == 3'd3)
                check("mask_8B_upper_zero", got >> 147, GW'(0));
        end

        // v_i held high: a 2-flit read repeats with one IDLE cycle between.
        c = rand_cmd();
        c.hd = 1'b0;
        @(negedge clk_i);
        drive_cmd(c);
        v_i = 1'b1;
        ready_and_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            vpat[i] = v_o;
            rpat[i] = ready_and_o;
            if (i == 5) v_i = 1'b0;
            @(negedge clk_i);
        end
        ready_and_i = 1'b0;
        check("b2b_v_pattern", GW'(vpat), GW'(6'b110110));
        check("b2b_ready_pattern", GW'(rpat), GW'(6'b001001));
        check("b2b_idle_after", GW'(v_o), GW'(0));

        // Reset during the fourth flit of a 10-flit write.
        c = rand_cmd();
        c.size = 3'd6;
        c.hd = 1'b1;
        @(negedge clk_i);
        drive_cmd(c);
        v_i = 1'b1;
        ready_and_i = 1'b1;
        @(negedge clk_i);            // accepted; flit 0 valid now
        v_i = 1'b0;
        repeat (3) @(negedge clk_i); // flit 3 valid now
        check("abort_pre_v_o", GW'(v_o), GW'(1));
        #1 reset_i = 1'b1;
        #1;
        check("abort_v_o_async", GW'(v_o), GW'(0));
        check("abort_ready_low", GW'(ready_and_o), GW'(0));
        @(negedge clk_i);
        #1 reset_i = 1'b0;
        #1;
        check("abort_idle_ready", GW'(ready_and_o), GW'(1));
        check("abort_idle_v_o", GW'(v_o), GW'(0));
        ready_and_i = 1'b0;
        c = rand_cmd();
        c.hd = 1'b0;
        transact(c, 100, "post_abort_read", got, nf);

        // Randomized mixed commands with 50% backpressure.
        for (int i = 0; i < 200; i++) begin
            transact(rand_cmd(), 50, $sformatf("rnd%0d", i), got, nf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
